axi_stream_pkt_fifo: RTL
========================

Name: axi_stream_pkt_fifo

Overview:
Next-generation AXI-stream buffer between an upstream master and a downstream slave. It adds packet framing (last flag), a store-and-forward mode, an oversize-packet escape, and occupancy/packet-count status. Arbitrary (non-power-of-2) depth is supported. Ready/valid semantics are unchanged from the existing stream FIFO: up_ready = not full, down_valid = data present (and packet-qualified in store-and-forward mode).

Parameters:
width, 8, data bits per beat
depth, 10, beats of storage (>= 2; need not be a power of 2)
pkt_mode, 1, 1 = store-and-forward (release only complete packets); 0 = cut-through
af_thresh, depth-2, level at or above which almost_full asserts

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
up_data  input  width  upstream beat data
up_last  input  1  upstream beat is last of packet
up_valid  input  1  upstream beat valid
up_ready  output  1  FIFO can accept a beat
down_data  output  width  downstream beat data
down_last  output  1  downstream beat is last of packet
down_valid  output  1  beat available to downstream
down_ready  input  1  downstream accepts beat
level  output  $clog2(depth+1)  beats currently stored
pkt_count  output  $clog2(depth+1)  complete packets stored
almost_full  output  1  level >= af_thresh
oversize  output  1  one-cycle pulse when the oversize escape engages

Behaviour:
- Reset (rst=1 at clk edge): wr_ptr=rd_ptr=0, level=0, pkt_count=0, flush=0, oversize=0. Resulting outputs: up_ready=1, down_valid=0, almost_full=0 (af_thresh>0). Storage contents are not reset. Reset mid-transfer discards all stored beats and any packet in flight.
- Storage: depth entries of {last, data}, written at wr_ptr. Pointers wrap from depth-1 to 0 by compare, not by power-of-2 masking.
- push = up_valid & up_ready; pop = down_valid & down_ready.
- up_ready = (level != depth). A push is refused when full even if a pop occurs in the same cycle (no full-bypass).
- Read is first-word-fall-through: down_data/down_last = mem[rd_ptr], combinational.
- Latency: a beat pushed at edge N can be popped at edge N+1 at the earliest (cut-through). No empty bypass.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- pkt_count: +1 on push with up_last, -1 on pop with down_last, unchanged when both occur.
- down_valid:
  - pkt_mode=0: level != 0.
  - pkt_mode=1: level != 0 & (pkt_count != 0 | flush).
- Oversize escape (pkt_mode=1 only):
  - Engages when level==depth and pkt_count==0 (the packet is longer than the FIFO): flush<=1, with oversize pulsed for exactly one cycle on the 0→1 transition.
  - While flush=1, beats drain cut-through.
  - flush clears on the pop of a beat with down_last=1.
  - pkt_count logic is unaffected; the oversize packet's last beat still counts +1/-1.
- Holding: while down_valid=1 and down_ready=0, down_data/down_last are stable. The block never drops a beat and never reorders.
- Two-state view (pkt_mode=1): IDLE/SF (flush=0) ↔ FLUSH (flush=1), transitions exactly as above. pkt_mode=0 has no state beyond the pointers.
- up_last is stored verbatim. A packet of one beat has up_last=1 on its only beat.

Decomposition:
- Shared package axi_stream_pkg: function for pointer increment-with-wrap, and a $clog2(depth+1) width helper constant function.
- One sub-module axi_stream_pkt_fifo_core: storage plus wr/rd pointers, level, full/empty. It is extended with the last bit from the existing FIFO.
- Top-level holds the handshake, pkt_count, flush FSM, and status outputs.

Test Plan (depth=4, width=8, pkt_mode=1 unless noted):
- Reset then idle → up_ready=1, down_valid=0, level=0, pkt_count=0, oversize=0.
- Push 3 beats 0x11,0x22,0x33(last) with down_ready=1 → down_valid stays 0 until after the 0x33 push edge. Then 0x11,0x22,0x33 pop on consecutive cycles, down_last only on 0x33; pkt_count goes 1→0.
- Push 4 beats without last → at level=4: oversize pulses 1 cycle, up_ready=0, down_valid=1. Drain 2 beats, push 0x55(last), pop all → flush clears after the 0x55 pop; no data lost.
- pkt_mode=0, depth=10: fill to 10 with down_ready=0 → up_ready=0, almost_full=1 from level 8. Simultaneous up_valid=1/down_ready=1 while full → only the pop occurs, level=9.
- Wrap-around: stream 25 single-beat packets (last=1) with random ready/valid → output sequence equals input sequence, pkt_count never exceeds 4.
- Assert rst with 2 beats stored and flush=1 → next cycle level=0, pkt_count=0, down_valid=0, flush=0.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared helpers for the AXI-stream packet FIFO: counter widths, pointer wrap, flush states.
package axi_stream_pkg;

  // Bits needed to count 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment that wraps by compare, so depth need not be a power of 2.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

  typedef enum logic {
    ST_SF    = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/axi_stream_pkt_fifo_core.sv
// Storage for {last, data} beats with wrap-by-compare pointers and an occupancy count.
// Writes and reads arrive already qualified by the caller's handshake.
module axi_stream_pkt_fifo_core
  import axi_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = cnt_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH:0]   i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH:0]   o_rd_data,
  output logic [LW-1:0]    o_level,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;

  // Storage write; contents are intentionally left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= PW'(ptr_inc(32'(r_wr_ptr), DEPTH));
      if (i_rd_en) r_rd_ptr <= PW'(ptr_inc(32'(r_rd_ptr), DEPTH));
      case ({i_wr_en, i_rd_en})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // First-word-fall-through read.
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);

endmodule

// File: rtl/axi_stream_pkt_fifo.sv
// AXI-stream FIFO with packet framing, optional store-and-forward release,
// an oversize-packet escape (flush) and occupancy / packet-count status.
module axi_stream_pkt_fifo
  import axi_stream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 10,
  parameter int PKT_MODE  = 1,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int LW       = cnt_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_up_data,
  input  logic             i_up_last,
  input  logic             i_up_valid,
  output logic             o_up_ready,
  output logic [WIDTH-1:0] o_down_data,
  output logic             o_down_last,
  output logic             o_down_valid,
  input  logic             i_down_ready,
  output logic [LW-1:0]    o_level,
  output logic [LW-1:0]    o_pkt_count,
  output logic             o_almost_full,
  output logic             o_oversize
);

  logic           w_push, w_pop, w_full, w_empty, w_flush, w_engage;
  logic [WIDTH:0] w_rd_word;
  logic [LW-1:0]  r_pkt_cnt;
  logic           r_oversize;
  flush_state_t   r_state, w_state_nxt;

  axi_stream_pkt_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_push),
    .i_wr_data ({i_up_last, i_up_data}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_word),
    .o_level   (o_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // No full-bypass: a full FIFO refuses the beat even if it pops this cycle.
  assign w_push = i_up_valid & o_up_ready;
  assign w_pop  = o_down_valid & i_down_ready;

  // Complete-packet count: a stored last flag marks one finished packet.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_push & i_up_last, w_pop & o_down_last})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + LW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - LW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Flush state register and the registered oversize pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_SF;
      r_oversize <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_oversize <= w_engage;
    end
  end

  // Full with no complete packet means the packet can never finish: drain it cut-through.
  always_comb begin
    w_state_nxt = r_state;
    w_engage    = 1'b0;
    case (r_state)
      ST_SF: begin
        if ((PKT_MODE != 0) && w_full && (r_pkt_cnt == '0)) begin
          w_engage    = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_pop && o_down_last) w_state_nxt = ST_SF;
      end
      default: w_state_nxt = ST_SF;
    endcase
  end

  assign w_flush       = (r_state == ST_FLUSH);
  assign o_up_ready    = ~w_full;
  assign o_down_valid  = ~w_empty & ((PKT_MODE == 0) | (r_pkt_cnt != '0) | w_flush);
  assign o_down_data   = w_rd_word[WIDTH-1:0];
  assign o_down_last   = w_rd_word[WIDTH];
  assign o_pkt_count   = r_pkt_cnt;
  assign o_almost_full = (int'(o_level) >= AF_THRESH);
  assign o_oversize    = r_oversize;

endmodule
